// File: rtl/qdrc_bist.sv
// Built-in self-test initiator for the QDR controller user port: writes a seeded
// address pattern over a range, reads it back in order and reports mismatches.
module qdrc_bist #(
  parameter int DATA_WIDTH     = 18,
  parameter int BW_WIDTH       = 2,
  parameter int ADDR_WIDTH     = 21,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] seed,
  input  logic [ADDR_WIDTH-1:0]   addr_first,
  input  logic [ADDR_WIDTH-1:0]   addr_last,
  input  logic                    phy_rdy,
  output logic                    usr_wr_strb,
  output logic                    usr_rd_strb,
  output logic [ADDR_WIDTH-1:0]   usr_addr,
  output logic [2*DATA_WIDTH-1:0] usr_wr_data,
  output logic [2*BW_WIDTH-1:0]   usr_wr_be,
  input  logic [2*DATA_WIDTH-1:0] usr_rd_data,
  input  logic                    usr_rd_dvld,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr
);

  localparam int WW = 2 * DATA_WIDTH;
  localparam int OW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_WRITE, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t                r_state;
  logic [WW-1:0]         r_seed;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH-1:0] r_eaddr;
  logic [OW-1:0]         r_outstanding;
  logic [TW-1:0]         r_timer;
  logic                  r_err_seen;
  logic                  r_wr_strb;
  logic                  r_rd_strb;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WW-1:0]         r_wr_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_timeout;
  logic [15:0]           r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;

  logic                  w_checking;
  logic                  w_issue_rd;
  logic                  w_rd_ok;
  logic                  w_spurious;
  logic                  w_mismatch;
  logic                  w_err_inc;
  logic [15:0]           w_err_next;
  logic [OW-1:0]         w_outstanding_next;
  logic [TW-1:0]         w_timer_next;
  logic                  w_timer_expired;

  // Low address bits, zero-extended or truncated to one QDR word, mirrored and seeded.
  function automatic logic [WW-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [WW-1:0] s);
    logic [DATA_WIDTH-1:0] l;
    l = DATA_WIDTH'(a);
    return {~l, l} ^ s;
  endfunction

  assign w_checking         = (r_state == S_READ) || (r_state == S_DRAIN);
  assign w_issue_rd         = (r_state == S_READ) && phy_rdy;
  assign w_rd_ok            = w_checking && usr_rd_dvld && (r_outstanding != '0);
  assign w_spurious         = w_checking && usr_rd_dvld && (r_outstanding == '0);
  assign w_mismatch         = w_rd_ok && (usr_rd_data != pattern(r_eaddr, r_seed));
  assign w_err_inc          = w_mismatch || w_spurious;
  assign w_err_next         = (w_err_inc && (r_err_count != 16'hFFFF)) ? r_err_count + 16'd1
                                                                       : r_err_count;
  assign w_outstanding_next = r_outstanding + OW'(w_issue_rd) - OW'(w_rd_ok);
  // Only time gaps while something is actually owed by the controller.
  assign w_timer_next       = (usr_rd_dvld || (r_outstanding == '0)) ? '0 :
                              (r_timer == TW'(TIMEOUT_CYCLES))       ? r_timer :
                                                                       r_timer + TW'(1);
  assign w_timer_expired    = (w_timer_next == TW'(TIMEOUT_CYCLES));

  assign usr_wr_strb    = r_wr_strb;
  assign usr_rd_strb    = r_rd_strb;
  assign usr_addr       = r_addr;
  assign usr_wr_data    = r_wr_data;
  assign usr_wr_be      = '1;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_seed           <= '0;
      r_last           <= '0;
      r_waddr          <= '0;
      r_raddr          <= '0;
      r_eaddr          <= '0;
      r_outstanding    <= '0;
      r_timer          <= '0;
      r_err_seen       <= 1'b0;
      r_wr_strb        <= 1'b0;
      r_rd_strb        <= 1'b0;
      r_addr           <= '0;
      r_wr_data        <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else begin
      r_wr_strb <= 1'b0;
      r_rd_strb <= 1'b0;
      if (w_checking) begin
        r_outstanding <= w_outstanding_next;
        r_timer       <= w_timer_next;
        r_err_count   <= w_err_next;
        if (w_rd_ok) r_eaddr <= r_eaddr + ADDR_WIDTH'(1);
        if (w_mismatch && !r_err_seen) begin
          r_first_err_addr <= r_eaddr;
          r_err_seen       <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_seed           <= seed;
            r_last           <= addr_last;
            r_waddr          <= addr_first;
            r_raddr          <= addr_first;
            r_eaddr          <= addr_first;
            r_outstanding    <= '0;
            r_timer          <= '0;
            r_err_seen       <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_timeout        <= 1'b0;
            r_pass           <= 1'b0;
            r_done           <= 1'b0;
            r_busy           <= 1'b1;
            r_state          <= S_WAIT_RDY;
          end
        end
        // The first write issues on the same edge that leaves WAIT_RDY.
        S_WAIT_RDY, S_WRITE: begin
          if (phy_rdy) begin
            r_wr_strb <= 1'b1;
            r_addr    <= r_waddr;
            r_wr_data <= pattern(r_waddr, r_seed);
            r_waddr   <= r_waddr + ADDR_WIDTH'(1);
            if (r_waddr == r_last) r_state <= S_READ;
            else                   r_state <= S_WRITE;
          end
        end
        S_READ: begin
          if (phy_rdy) begin
            r_rd_strb <= 1'b1;
            r_addr    <= r_raddr;
            r_raddr   <= r_raddr + ADDR_WIDTH'(1);
            if (r_raddr == r_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_outstanding == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 16'd0) && !r_timeout;
          end else if (w_timer_expired) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qdrc_bist.sv
// Self-checking bench for qdrc_bist: a QDR user-port model with fixed read latency,
// a table of whole-test vectors, and hand-written timing/pause/reset sequences.
module tb_qdrc_bist;

  localparam int DW  = 18;
  localparam int BW  = 2;
  localparam int AW  = 21;
  localparam int TO  = 16;
  localparam int LAT = 10;

  logic            clk = 1'b0;
  logic            reset_n, start, phy_rdy;
  logic [2*DW-1:0] seed;
  logic [AW-1:0]   addr_first, addr_last;
  logic            usr_wr_strb, usr_rd_strb;
  logic [AW-1:0]   usr_addr;
  logic [2*DW-1:0] usr_wr_data, usr_rd_data;
  logic [2*BW-1:0] usr_wr_be;
  logic            usr_rd_dvld;
  logic            busy, done, pass, timeout;
  logic [15:0]     err_count;
  logic [AW-1:0]   first_err_addr;

  always #5 clk = ~clk;

  qdrc_bist #(.DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .seed(seed),
    .addr_first(addr_first), .addr_last(addr_last), .phy_rdy(phy_rdy),
    .usr_wr_strb(usr_wr_strb), .usr_rd_strb(usr_rd_strb), .usr_addr(usr_addr),
    .usr_wr_data(usr_wr_data), .usr_wr_be(usr_wr_be), .usr_rd_data(usr_rd_data),
    .usr_rd_dvld(usr_rd_dvld), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  typedef struct {
    string         name;
    logic [35:0]   seed;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    bit            corrupt;
    logic [AW-1:0] corruptAddr;
    bit            drop;
    int            nWords;
    bit            expPass;
    bit            expTimeout;
    logic [15:0]   expErr;
    logic [AW-1:0] expFea;
  } vec_t;

  typedef struct {
    int          due;
    logic [35:0] data;
  } rsp_t;

  int            nCompared = 0;
  int            nMismatched = 0;
  int            cyc = 0;
  logic          phyAtEdge = 1'b0;
  rsp_t          rspQ[$];
  logic [35:0]   mem[logic [AW-1:0]];
  logic [AW-1:0] wrAddr[$], rdAddr[$];
  logic [35:0]   wrData[$];
  int            wrCyc[$], rdCyc[$];
  int            badWrites, bothStrobe, phyViol, lastDvldCyc, t0, doneCyc;
  logic [35:0]   curSeed;
  bit            corruptEn, dropEn;
  logic [AW-1:0] corruptAddr, dropAddr;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) phyAtEdge <= phy_rdy;

  function automatic logic [35:0] tbPattern(input logic [AW-1:0] a, input logic [35:0] s);
    logic [17:0] l;
    l = a[17:0];
    return {~l, l} ^ s;
  endfunction

  // Controller model: stores writes, returns reads LAT cycles after the strobe, in order.
  initial begin
    rsp_t        r;
    logic [35:0] d;
    usr_rd_dvld = 1'b0;
    usr_rd_data = '0;
    forever begin
      @(negedge clk);
      if (usr_wr_strb) begin
        mem[usr_addr] = usr_wr_data;
        wrAddr.push_back(usr_addr);
        wrData.push_back(usr_wr_data);
        wrCyc.push_back(cyc);
        if (usr_wr_data !== tbPattern(usr_addr, curSeed)) badWrites++;
      end
      if (usr_rd_strb) begin
        d = mem.exists(usr_addr) ? mem[usr_addr] : 36'h0;
        if (corruptEn && usr_addr == corruptAddr) d[0] = ~d[0];
        if (!(dropEn && usr_addr == dropAddr)) rspQ.push_back('{cyc + LAT, d});
        rdAddr.push_back(usr_addr);
        rdCyc.push_back(cyc);
      end
      if (usr_wr_strb && usr_rd_strb) bothStrobe++;
      if ((usr_wr_strb || usr_rd_strb) && !phyAtEdge) phyViol++;
      usr_rd_dvld = 1'b0;
      if (rspQ.size() > 0 && rspQ[0].due == cyc) begin
        r = rspQ.pop_front();
        usr_rd_dvld = 1'b1;
        usr_rd_data = r.data;
        lastDvldCyc = cyc;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wrAddr.delete(); rdAddr.delete(); wrData.delete(); wrCyc.delete(); rdCyc.delete();
    badWrites = 0; bothStrobe = 0; phyViol = 0;
    curSeed = v.seed; corruptEn = v.corrupt; corruptAddr = v.corruptAddr;
    dropEn = v.drop; dropAddr = v.last;
    @(negedge clk);
    seed = v.seed; addr_first = v.first; addr_last = v.last; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        doneCyc = cyc;
      end
    end
    checkOutput({name, "_done_reached"}, 64'(seen), 64'd1);
  endtask

  task automatic checkRun(input vec_t v);
    int addrErr = 0;
    for (int i = 0; i < wrAddr.size(); i++) if (wrAddr[i] !== v.first + AW'(i)) addrErr++;
    for (int i = 0; i < rdAddr.size(); i++) if (rdAddr[i] !== v.first + AW'(i)) addrErr++;
    checkOutput({v.name, "_done"}, 64'(done), 64'd1);
    checkOutput({v.name, "_busy"}, 64'(busy), 64'd0);
    checkOutput({v.name, "_pass"}, 64'(pass), 64'(v.expPass));
    checkOutput({v.name, "_timeout"}, 64'(timeout), 64'(v.expTimeout));
    checkOutput({v.name, "_err_count"}, 64'(err_count), 64'(v.expErr));
    checkOutput({v.name, "_first_err_addr"}, 64'(first_err_addr), 64'(v.expFea));
    checkOutput({v.name, "_write_count"}, 64'(wrAddr.size()), 64'(v.nWords));
    checkOutput({v.name, "_read_count"}, 64'(rdAddr.size()), 64'(v.nWords));
    checkOutput({v.name, "_write_data_errors"}, 64'(badWrites), 64'd0);
    checkOutput({v.name, "_address_order_errors"}, 64'(addrErr), 64'd0);
    checkOutput({v.name, "_both_strobes"}, 64'(bothStrobe), 64'd0);
    checkOutput({v.name, "_strobe_without_phy_rdy"}, 64'(phyViol), 64'd0);
  endtask

  task automatic runVector(input vec_t v);
    $display("[TB] running %s", v.name);
    applyStimulus(v);
    waitDone(v.name);
    checkRun(v);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_wr_strb"}, 64'(usr_wr_strb), 64'd0);
    checkOutput({name, "_rd_strb"}, 64'(usr_rd_strb), 64'd0);
    checkOutput({name, "_addr"}, 64'(usr_addr), 64'd0);
    checkOutput({name, "_wr_data"}, 64'(usr_wr_data), 64'd0);
    checkOutput({name, "_wr_be"}, 64'(usr_wr_be), 64'hF);
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_done"}, 64'(done), 64'd0);
    checkOutput({name, "_pass"}, 64'(pass), 64'd0);
    checkOutput({name, "_timeout"}, 64'(timeout), 64'd0);
    checkOutput({name, "_err_count"}, 64'(err_count), 64'd0);
    checkOutput({name, "_first_err_addr"}, 64'(first_err_addr), 64'd0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   maxGap;
    bit   reached;

    vecs[0] = '{"nominal",   36'h0,         21'h0,      21'h3,      0, 21'h0,      0, 4, 1, 0, 16'd0, 21'h0};
    vecs[1] = '{"corrupt2",  36'h0,         21'h0,      21'h3,      1, 21'h2,      0, 4, 0, 0, 16'd1, 21'h2};
    vecs[2] = '{"wrap",      36'h5A5A5A5A5, 21'h1FFFFE, 21'h000001, 0, 21'h0,      0, 4, 1, 0, 16'd0, 21'h0};
    vecs[3] = '{"single",    36'h123456789, 21'h5,      21'h5,      1, 21'h5,      0, 1, 0, 0, 16'd1, 21'h5};
    vecs[4] = '{"droplast",  36'h0,         21'h10,     21'h13,     0, 21'h0,      1, 4, 0, 1, 16'd0, 21'h0};
    vecs[5] = '{"wrapcorr",  36'hFFFFFFFFF, 21'h1FFFFE, 21'h000001, 1, 21'h1FFFFF, 0, 4, 0, 0, 16'd1, 21'h1FFFFF};

    reset_n = 1'b0; start = 1'b0; phy_rdy = 1'b1; seed = '0; addr_first = '0; addr_last = '0;
    curSeed = '0; corruptEn = 0; dropEn = 0; corruptAddr = '0; dropAddr = '0;
    badWrites = 0; bothStrobe = 0; phyViol = 0; lastDvldCyc = 0; t0 = 0; doneCyc = 0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) runVector(vecs[i]);

    // Nominal run timing: writes at 2..5, reads at 6..9, done roughly ten cycles later.
    runVector(vecs[0]);
    checkOutput("first_write_cycle", 64'(wrCyc[0] - t0), 64'd2);
    checkOutput("last_write_cycle", 64'(wrCyc[3] - t0), 64'd5);
    checkOutput("first_read_cycle", 64'(rdCyc[0] - t0), 64'd6);
    checkOutput("last_read_cycle", 64'(rdCyc[3] - t0), 64'd9);
    checkOutput("write_data_addr1", 64'(wrData[1]), 64'({18'h3FFFE, 18'h00001}));
    checkOutput("done_cycle_near_20", 64'((doneCyc - t0) >= 18 && (doneCyc - t0) <= 24), 64'd1);

    // Wrap through zero in issue order.
    runVector(vecs[2]);
    checkOutput("wrap_addr0", 64'(wrAddr[0]), 64'h1FFFFE);
    checkOutput("wrap_addr1", 64'(wrAddr[1]), 64'h1FFFFF);
    checkOutput("wrap_addr2", 64'(wrAddr[2]), 64'h0);
    checkOutput("wrap_addr3", 64'(wrAddr[3]), 64'h1);

    // Timeout fires after 16 dvld-free cycles following the last returned word.
    runVector(vecs[4]);
    checkOutput("timeout_latency", 64'(doneCyc - lastDvldCyc), 64'd17);

    // phy_rdy low at start for 50 cycles, ignored start while busy, 3-cycle mid-write pause.
    v = '{"phypause", 36'hABCDE1234, 21'h20, 21'h27, 0, 21'h0, 0, 8, 1, 0, 16'd0, 21'h0};
    $display("[TB] running %s", v.name);
    phy_rdy = 1'b0;
    applyStimulus(v);
    @(negedge clk);
    start = 1'b1; seed = 36'h111111111; addr_first = 21'h0; addr_last = 21'h2;
    @(negedge clk);
    start = 1'b0;
    repeat (46) @(negedge clk);
    checkOutput("phypause_busy_while_waiting", 64'(busy), 64'd1);
    checkOutput("phypause_no_writes_while_low", 64'(wrAddr.size()), 64'd0);
    phy_rdy = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      @(negedge clk);
      if (wrAddr.size() >= 3) reached = 1'b1;
    end
    checkOutput("phypause_writes_started", 64'(reached), 64'd1);
    phy_rdy = 1'b0;
    repeat (3) @(negedge clk);
    phy_rdy = 1'b1;
    waitDone(v.name);
    checkRun(v);
    maxGap = 0;
    for (int i = 1; i < wrCyc.size(); i++) if (wrCyc[i] - wrCyc[i-1] > maxGap) maxGap = wrCyc[i] - wrCyc[i-1];
    checkOutput("phypause_write_gap", 64'(maxGap), 64'd4);

    // Reset mid-READ: outputs return to reset values and stale read data is ignored.
    v = '{"resetrun", 36'h0F0F0F0F0, 21'h40, 21'h47, 0, 21'h0, 0, 8, 1, 0, 16'd0, 21'h0};
    $display("[TB] running %s (interrupted)", v.name);
    applyStimulus(v);
    reached = 1'b0;
    for (int k = 0; k < 200 && !reached; k++) begin
      @(negedge clk);
      if (rdAddr.size() >= 3) reached = 1'b1;
    end
    checkOutput("resetrun_reached_read", 64'(reached), 64'd1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("midreset");
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("stale_dvld_err_count", 64'(err_count), 64'd0);
    checkOutput("stale_dvld_busy", 64'(busy), 64'd0);
    checkOutput("stale_dvld_done", 64'(done), 64'd0);
    runVector(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
